ps2_ascii_decoder: RTL and testbench

//  Stateful PS/2 set-2 scan-code to ASCII decoder with an output FIFO. Sits between the PS/2

---
 rtl/ps2_ascii_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
`default_nettype none
// =============================================================================
// Module   : ps2_ascii_decoder
// Brief    : PS/2 set-2 scan-code to ASCII decoder with first-word-fall-through
//            output FIFO. Optional caps lock enabled by defining PS2_CAPSLOCK_EN.
// Revision : 1.0 - initial release
// =============================================================================
module ps2_ascii_decoder #(
    parameter int         FIFO_AW      = 2,
    parameter bit         DROP_UNKNOWN = 1'b1,
    parameter logic [7:0] UNK_CHAR     = 8'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    input  logic       clr_overflow,
    output logic       overflow,
    output logic       shift_active,
    output logic       caps_active
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BRK     = 2'd1;
    localparam logic [1:0] c_ST_EXT     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    localparam int             c_DEPTH  = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL = (FIFO_AW + 1)'(c_DEPTH);

    localparam logic [7:0] c_SC_BRK    = 8'hF0;
    localparam logic [7:0] c_SC_EXT    = 8'hE0;
    localparam logic [7:0] c_SC_LSHIFT = 8'h12;
    localparam logic [7:0] c_SC_RSHIFT = 8'h59;

    // Returns {mapped, ascii}; letters flip case on shift XOR caps, others on shift only.
    function automatic logic [8:0] f_translate(input logic [7:0] code,
                                               input logic       shift,
                                               input logic       caps);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h61}; 8'h32: r = {1'b1, 8'h62}; 8'h21: r = {1'b1, 8'h63};
            8'h23: r = {1'b1, 8'h64}; 8'h24: r = {1'b1, 8'h65}; 8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67}; 8'h33: r = {1'b1, 8'h68}; 8'h43: r = {1'b1, 8'h69};
            8'h3B: r = {1'b1, 8'h6A}; 8'h42: r = {1'b1, 8'h6B}; 8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D}; 8'h31: r = {1'b1, 8'h6E}; 8'h44: r = {1'b1, 8'h6F};
            8'h4D: r = {1'b1, 8'h70}; 8'h15: r = {1'b1, 8'h71}; 8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73}; 8'h2C: r = {1'b1, 8'h74}; 8'h3C: r = {1'b1, 8'h75};
            8'h2A: r = {1'b1, 8'h76}; 8'h1D: r = {1'b1, 8'h77}; 8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79}; 8'h1A: r = {1'b1, 8'h7A};
            8'h45: r = {1'b1, shift ? 8'h29 : 8'h30};
            8'h16: r = {1'b1, shift ? 8'h21 : 8'h31};
            8'h1E: r = {1'b1, shift ? 8'h40 : 8'h32};
            8'h26: r = {1'b1, shift ? 8'h23 : 8'h33};
            8'h25: r = {1'b1, shift ? 8'h24 : 8'h34};
            8'h2E: r = {1'b1, shift ? 8'h25 : 8'h35};
            8'h36: r = {1'b1, shift ? 8'h5E : 8'h36};
            8'h3D: r = {1'b1, shift ? 8'h26 : 8'h37};
            8'h3E: r = {1'b1, shift ? 8'h2A : 8'h38};
            8'h46: r = {1'b1, shift ? 8'h28 : 8'h39};
            8'h0E: r = {1'b1, shift ? 8'h7E : 8'h60};
            8'h4E: r = {1'b1, shift ? 8'h5F : 8'h2D};
            8'h55: r = {1'b1, shift ? 8'h2B : 8'h3D};
            8'h54: r = {1'b1, shift ? 8'h7B : 8'h5B};
            8'h5B: r = {1'b1, shift ? 8'h7D : 8'h5D};
            8'h5D: r = {1'b1, shift ? 8'h7C : 8'h5C};
            8'h4C: r = {1'b1, shift ? 8'h3A : 8'h3B};
            8'h52: r = {1'b1, shift ? 8'h22 : 8'h27};
            8'h41: r = {1'b1, shift ? 8'h3C : 8'h2C};
            8'h49: r = {1'b1, shift ? 8'h3E : 8'h2E};
            8'h4A: r = {1'b1, shift ? 8'h3F : 8'h2F};
            8'h29: r = {1'b1, 8'h20};
            8'h5A: r = {1'b1, 8'h0D};
            8'h66: r = {1'b1, 8'h08};
            default: r = 9'h000;
        endcase
        // Only the letter table yields codes in 'a'..'z', so this upcases letters alone.
        if (r[8] && (r[7:0] >= 8'h61) && (r[7:0] <= 8'h7A) && (shift ^ caps))
            r[7:0] = r[7:0] - 8'h20;
        return r;
    endfunction

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_lshift;
    logic       r_rshift;
    logic       r_overflow;
    logic       w_hit;
    logic [7:0] w_char;
    logic [7:0] w_push_data;
    logic       w_push;
    logic       w_set_l;
    logic       w_set_r;
    logic       w_clr_l;
    logic       w_clr_r;
`ifdef PS2_CAPSLOCK_EN
    logic       w_caps_make;
    logic       w_caps_brk;
`endif

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    assign shift_active     = r_lshift | r_rshift;
    assign {w_hit, w_char}  = f_translate(scan_code, shift_active, caps_active);
    assign w_push_data      = w_hit ? w_char : UNK_CHAR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (scan_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (scan_code == c_SC_BRK)      w_next_state = c_ST_BRK;
                    else if (scan_code == c_SC_EXT) w_next_state = c_ST_EXT;
                end
                c_ST_BRK:     w_next_state = c_ST_IDLE;
                c_ST_EXT:     w_next_state = (scan_code == c_SC_BRK) ? c_ST_EXT_BRK : c_ST_IDLE;
                c_ST_EXT_BRK: w_next_state = c_ST_IDLE;
                default:      w_next_state = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_push  = 1'b0;
        w_set_l = 1'b0;
        w_set_r = 1'b0;
        w_clr_l = 1'b0;
        w_clr_r = 1'b0;
`ifdef PS2_CAPSLOCK_EN
        w_caps_make = 1'b0;
        w_caps_brk  = 1'b0;
`endif
        if (scan_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (scan_code == c_SC_LSHIFT)      w_set_l = 1'b1;
                    else if (scan_code == c_SC_RSHIFT) w_set_r = 1'b1;
`ifdef PS2_CAPSLOCK_EN
                    else if (scan_code == 8'h58)       w_caps_make = 1'b1;
`endif
                    else if ((scan_code != c_SC_BRK) && (scan_code != c_SC_EXT))
                        w_push = w_hit || !DROP_UNKNOWN;
                end
                c_ST_BRK: begin
                    w_clr_l = (scan_code == c_SC_LSHIFT);
                    w_clr_r = (scan_code == c_SC_RSHIFT);
`ifdef PS2_CAPSLOCK_EN
                    w_caps_brk = (scan_code == 8'h58);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
        end else begin
            if (w_set_l)      r_lshift <= 1'b1;
            else if (w_clr_l) r_lshift <= 1'b0;
            if (w_set_r)      r_rshift <= 1'b1;
            else if (w_clr_r) r_rshift <= 1'b0;
        end
    end

`ifdef PS2_CAPSLOCK_EN
    logic r_caps;
    logic r_caps_held;

    // Held-key typematic repeats must not re-toggle, hence the held latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_caps_make) begin
            if (!r_caps_held) r_caps <= ~r_caps;
            r_caps_held <= 1'b1;
        end else if (w_caps_brk) begin
            r_caps_held <= 1'b0;
        end
    end

    assign caps_active = r_caps;
`else
    assign caps_active = 1'b0;
`endif

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = ascii_ready && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (clr_overflow)          r_overflow <= 1'b0;
        end
    end

    assign ascii_valid = !w_empty;
    assign ascii_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_ps2_ascii_decoder
// Brief    : Self-checking bench: directed scenarios plus a randomized run against
//            a table-driven keyboard model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ps2_ascii_decoder;

`ifdef PS2_CAPSLOCK_EN
    localparam bit CAPS_EN = 1'b1;
`else
    localparam bit CAPS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       ascii_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       overflow;
    logic       shift_active;
    logic       caps_active;

    logic       u_ready = 1'b1;
    logic       u_clr = 1'b0;
    logic [7:0] u_data;
    logic       u_valid;
    logic       u_overflow;
    logic       u_shift;
    logic       u_caps;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_ascii_decoder #(.FIFO_AW(2), .DROP_UNKNOWN(1'b1), .UNK_CHAR(8'h2A)) dut (
        .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
        .clr_overflow(clr_overflow), .overflow(overflow),
        .shift_active(shift_active), .caps_active(caps_active)
    );

    ps2_ascii_decoder #(.FIFO_AW(2), .DROP_UNKNOWN(1'b0), .UNK_CHAR(8'h2A)) dut_u (
        .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .ascii_data(u_data), .ascii_valid(u_valid), .ascii_ready(u_ready),
        .clr_overflow(u_clr), .overflow(u_overflow),
        .shift_active(u_shift), .caps_active(u_caps)
    );

    // Keyboard layout model: scan code tables alongside the characters they print.
    byte unsigned letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    byte unsigned digit_sc [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};
    byte unsigned punct_sc [11]  = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                     8'h41, 8'h49, 8'h4A};
    byte unsigned digit_shifted [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                         8'h2A, 8'h28};
    byte unsigned punct_plain [11]   = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                         8'h2C, 8'h2E, 8'h2F};
    byte unsigned punct_shifted [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                         8'h3C, 8'h3E, 8'h3F};

    byte unsigned pool [20] = '{8'h1C, 8'h32, 8'h1A, 8'h45, 8'h16, 8'h4E, 8'h4A, 8'h5D, 8'h52,
                                8'h29, 8'h5A, 8'h66, 8'h07, 8'h12, 8'h59, 8'hF0, 8'hF0,
                                8'hE0, 8'h75, 8'h58};

    byte unsigned m_q[$];
    bit m_lsh, m_rsh, m_caps, m_held, m_brk, m_ext, m_ovf;

    function automatic bit model_char(input byte unsigned code, input bit shift, input bit caps,
                                      output byte unsigned ch);
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (code == letter_sc[i]) begin
                ch = 8'(((shift ^ caps) ? 65 : 97) + i);
                return 1'b1;
            end
        for (int i = 0; i < 10; i++)
            if (code == digit_sc[i]) begin
                ch = shift ? digit_shifted[i] : 8'(48 + i);
                return 1'b1;
            end
        for (int i = 0; i < 11; i++)
            if (code == punct_sc[i]) begin
                ch = shift ? punct_shifted[i] : punct_plain[i];
                return 1'b1;
            end
        if (code == 8'h29) begin ch = 8'h20; return 1'b1; end
        if (code == 8'h5A) begin ch = 8'h0D; return 1'b1; end
        if (code == 8'h66) begin ch = 8'h08; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        ascii_ready = 1'b1;
        @(negedge clk);
        ascii_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ascii_valid !== 1'b0 || ascii_data !== 8'h00 || overflow !== 1'b0 ||
            shift_active !== 1'b0 || caps_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h ovf=%b shift=%b caps=%b, need all 0",
                     ascii_valid, ascii_data, overflow, shift_active, caps_active);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        send_byte(8'h1C);
        checks++;
        if (ascii_valid !== 1'b1 || ascii_data !== 8'h61) begin
            errors++;
            $display("FAIL single_a: valid=%b data=%h, need 1/61", ascii_valid, ascii_data);
        end
        pop_one();
        checks++;
        if (ascii_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: valid=%b, need 0", ascii_valid);
        end
    endtask

    task automatic test_shift();
        send_byte(8'h12);
        checks++;
        if (shift_active !== 1'b1) begin
            errors++;
            $display("FAIL shift_set: shift=%b, need 1", shift_active);
        end
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        checks++;
        if (shift_active !== 1'b0) begin
            errors++;
            $display("FAIL shift_clr: shift=%b, need 0", shift_active);
        end
        send_byte(8'h1C);
        checks++;
        if (ascii_data !== 8'h41) begin
            errors++;
            $display("FAIL shift_upper: data=%h, need 41", ascii_data);
        end
        pop_one();
        checks++;
        if (ascii_valid !== 1'b1 || ascii_data !== 8'h61) begin
            errors++;
            $display("FAIL shift_lower: valid=%b data=%h, need 1/61", ascii_valid, ascii_data);
        end
        pop_one();
        checks++;
        if (ascii_valid !== 1'b0) begin
            errors++;
            $display("FAIL shift_breaks_push: valid=%b, need 0", ascii_valid);
        end
    endtask

    task automatic test_digits_punct();
        send_byte(8'h12);
        send_byte(8'h16);
        checks++;
        if (ascii_data !== 8'h21) begin
            errors++;
            $display("FAIL shift_1: data=%h, need 21", ascii_data);
        end
        pop_one();
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h59);
        send_byte(8'h4A);
        checks++;
        if (ascii_data !== 8'h3F) begin
            errors++;
            $display("FAIL rshift_slash: data=%h, need 3F", ascii_data);
        end
        pop_one();
        send_byte(8'hF0);
        send_byte(8'h59);
        send_byte(8'h45);
        checks++;
        if (ascii_data !== 8'h30) begin
            errors++;
            $display("FAIL plain_0: data=%h, need 30", ascii_data);
        end
        pop_one();
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (ascii_valid !== 1'b0) begin
            errors++;
            $display("FAIL ext_nopush: valid=%b, need 0", ascii_valid);
        end
        send_byte(8'h1C);
        checks++;
        if (ascii_valid !== 1'b1 || ascii_data !== 8'h61) begin
            errors++;
            $display("FAIL ext_back_idle: valid=%b data=%h, need 1/61", ascii_valid, ascii_data);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        int n;
        ascii_ready = 1'b0;
        repeat (5) send_byte(8'h1C);
        checks++;
        if (ascii_valid !== 1'b1 || ascii_data !== 8'h61 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: valid=%b data=%h ovf=%b, need 1/61/1",
                     ascii_valid, ascii_data, overflow);
        end
        @(negedge clk);
        scan_code = 8'h1C; scan_valid = 1'b1; clr_overflow = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0; clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b, need 1", overflow);
        end
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, need 0", overflow);
        end
        @(negedge clk);
        scan_code = 8'h1C; scan_valid = 1'b1; ascii_ready = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0; ascii_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: ovf=%b, need 0", overflow);
        end
        n = 0;
        ascii_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ascii_valid) n++;
            @(negedge clk);
        end
        ascii_ready = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL full_count: entries=%0d, need 4", n);
        end
    endtask

    task automatic test_unknown();
        send_byte(8'h07);
        checks++;
        if (ascii_valid !== 1'b0) begin
            errors++;
            $display("FAIL unk_drop: valid=%b, need 0", ascii_valid);
        end
        checks++;
        if (u_valid !== 1'b1 || u_data !== 8'h2A) begin
            errors++;
            $display("FAIL unk_push: valid=%b data=%h, need 1/2A", u_valid, u_data);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h12);
        send_byte(8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (shift_active !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_shift: shift=%b, need 0", shift_active);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h1C);
        checks++;
        if (ascii_valid !== 1'b1 || ascii_data !== 8'h61) begin
            errors++;
            $display("FAIL rst_mid_prefix: valid=%b data=%h, need 1/61", ascii_valid, ascii_data);
        end
        pop_one();
    endtask

    task automatic test_caps();
        if (CAPS_EN) begin
            send_byte(8'h58);
            send_byte(8'h58);
            send_byte(8'hF0);
            send_byte(8'h58);
            send_byte(8'h1C);
            checks++;
            if (caps_active !== 1'b1 || ascii_data !== 8'h41) begin
                errors++;
                $display("FAIL caps_toggle: caps=%b data=%h, need 1/41", caps_active, ascii_data);
            end
            pop_one();
            send_byte(8'h58);
            send_byte(8'hF0);
            send_byte(8'h58);
            checks++;
            if (caps_active !== 1'b0) begin
                errors++;
                $display("FAIL caps_retoggle: caps=%b, need 0", caps_active);
            end
        end else begin
            send_byte(8'h58);
            checks++;
            if (caps_active !== 1'b0 || ascii_valid !== 1'b0) begin
                errors++;
                $display("FAIL caps_absent: caps=%b valid=%b, need 0/0", caps_active, ascii_valid);
            end
        end
    endtask

    task automatic test_random();
        bit sv, rdy, clr, pop, full, push, hit, set_ov;
        byte unsigned code, ch;
        do_reset();
        m_q.delete();
        {m_lsh, m_rsh, m_caps, m_held, m_brk, m_ext, m_ovf} = '0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            checks++;
            if (ascii_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid cyc %0d: valid=%b, need %b", cyc, ascii_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if (ascii_data !== m_q[0]) begin
                    errors++;
                    $display("FAIL rnd_data cyc %0d: data=%h, need %h", cyc, ascii_data, m_q[0]);
                end
            end
            checks++;
            if (overflow !== m_ovf || shift_active !== (m_lsh | m_rsh) || caps_active !== m_caps) begin
                errors++;
                $display("FAIL rnd_flags cyc %0d: ovf=%b shift=%b caps=%b, need %b/%b/%b", cyc,
                         overflow, shift_active, caps_active, m_ovf, m_lsh | m_rsh, m_caps);
            end
            sv   = ($urandom_range(0, 2) == 0);
            code = pool[$urandom_range(0, 19)];
            rdy  = (cyc < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            scan_valid = sv; scan_code = code; ascii_ready = rdy; clr_overflow = clr;
            pop  = rdy && (m_q.size() != 0);
            full = (m_q.size() == 4);
            push = 1'b0;
            ch   = 8'h00;
            if (sv) begin
                if (!m_brk && !m_ext) begin
                    if (code == 8'hF0)                 m_brk = 1'b1;
                    else if (code == 8'hE0)            m_ext = 1'b1;
                    else if (code == 8'h12)            m_lsh = 1'b1;
                    else if (code == 8'h59)            m_rsh = 1'b1;
                    else if (CAPS_EN && code == 8'h58) begin
                        if (!m_held) m_caps = !m_caps;
                        m_held = 1'b1;
                    end else begin
                        hit  = model_char(code, m_lsh | m_rsh, m_caps, ch);
                        push = hit;
                    end
                end else if (m_brk && !m_ext) begin
                    if (code == 8'h12) m_lsh = 1'b0;
                    if (code == 8'h59) m_rsh = 1'b0;
                    if (code == 8'h58) m_held = 1'b0;
                    m_brk = 1'b0;
                end else if (m_ext && !m_brk) begin
                    if (code == 8'hF0) m_brk = 1'b1;
                    else               m_ext = 1'b0;
                end else begin
                    m_brk = 1'b0;
                    m_ext = 1'b0;
                end
            end
            if (pop) void'(m_q.pop_front());
            set_ov = 1'b0;
            if (push) begin
                if (full && !pop) set_ov = 1'b1;
                else              m_q.push_back(ch);
            end
            m_ovf = set_ov ? 1'b1 : (clr ? 1'b0 : m_ovf);
        end
        @(negedge clk);
        scan_valid = 1'b0; ascii_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_shift();
        test_digits_punct();
        test_extended();
        test_overflow();
        test_unknown();
        test_reset_mid();
        test_caps();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
